aes_ctr_sequencer: RTL and testbench

//  CTR-mode job sequencer between the register file and the AES core wrapper. Per block: issues
//  the counter block to the core, buffers one message block, XORs it with the returned keystream
//  and presents the result downstream on a valid/ready port. Low CTR_W counter bits increment
//  per block. Reports busy/done/error in the CSR status format (busy=2, done=1).

---
 rtl/aes_ctr_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_aes_ctr_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer
//
// CTR-mode job sequencer sitting between the CSR block and the AES core wrapper.
// For each block of a job it:
//   1. issues the current counter block to the AES core (aes_start / aes_block),
//   2. buffers one message block from the upstream valid/ready port,
//   3. captures the returned keystream,
//   4. presents message XOR keystream downstream on a valid/ready port.
// Only the low CTR_W counter bits increment per block (wrapping), upper bits are fixed.
// CTR mode is symmetric, so the same path serves encryption and decryption.
//
// Ports
//   clock, reset       single clock; synchronous active-high reset
//   start, iv,         job request pulse with initial counter block and block count
//   num_blocks         (num_blocks == 0 completes immediately as an empty job)
//   in_data/valid/     message input; single-entry buffer, accepted only while
//   in_ready           waiting for the current block
//   aes_start/block    one-cycle encrypt request; aes_block stable until aes_done
//   aes_done/keystream keystream return from the AES core
//   out_data/valid/    result output, held until out_ready
//   out_ready
//   busy, done         job in progress / one-cycle end-of-job pulse
//   status             {err, busy, done_sticky}
//   status_update      one-cycle strobe whenever status changes
//
// All outputs are registered.

module aes_ctr_sequencer #(
    parameter int unsigned W     = 128,
    parameter int unsigned CTR_W = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             start,
    input  logic [W-1:0]     iv,
    input  logic [CNT_W-1:0] num_blocks,

    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,

    output logic             aes_start,
    output logic [W-1:0]     aes_block,
    input  logic             aes_done,
    input  logic [W-1:0]     aes_keystream,

    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,

    output logic             busy,
    output logic             done,
    output logic [2:0]       status,
    output logic             status_update
);

    typedef enum logic [1:0] {
        StIdle,
        StKs,
        StWait,
        StOut
    } state_e;

    // Selects the counter bits that increment; 1 << W wraps to 0 so CTR_W == W gives all ones.
    localparam logic [W-1:0] LowMask = (W'(1) << CTR_W) - W'(1);

    state_e             state_q, state_d;
    logic [W-1:0]       ctr_q, ctr_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [W-1:0]       msg_q, msg_d;
    logic               msg_valid_q, msg_valid_d;
    logic [W-1:0]       ks_q, ks_d;
    logic               ks_valid_q, ks_valid_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               aes_start_q, aes_start_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               done_sticky_q, done_sticky_d;
    logic               err_q, err_d;
    logic [2:0]         status_q, status_d;
    logic               status_update_q, status_update_d;

    logic [W-1:0]       ctr_inc;

    // Increment the low field only; the carry out of bit CTR_W-1 is discarded by the mask.
    assign ctr_inc = (ctr_q & ~LowMask) | ((ctr_q + W'(1)) & LowMask);

    always_comb begin
        state_d       = state_q;
        ctr_d         = ctr_q;
        remaining_d   = remaining_q;
        msg_d         = msg_q;
        msg_valid_d   = msg_valid_q;
        ks_d          = ks_q;
        ks_valid_d    = ks_valid_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        done_d        = 1'b0;
        done_sticky_d = done_sticky_q;
        err_d         = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d = 1'b0;
                    if (num_blocks != '0) begin
                        ctr_d         = iv;
                        remaining_d   = num_blocks;
                        msg_valid_d   = 1'b0;
                        ks_valid_d    = 1'b0;
                        done_sticky_d = 1'b0;
                        state_d       = StKs;
                    end else begin
                        // Empty job: finish immediately without touching the core.
                        done_d        = 1'b1;
                        done_sticky_d = 1'b1;
                    end
                end
            end

            StKs: begin
                state_d = StWait;
            end

            StWait: begin
                if (in_valid && in_ready_q) begin
                    msg_d       = in_data;
                    msg_valid_d = 1'b1;
                end
                if (aes_done && !ks_valid_q) begin
                    ks_d       = aes_keystream;
                    ks_valid_d = 1'b1;
                end
                // Use the next-state views so a same-cycle arrival goes straight to OUT.
                if (msg_valid_d && ks_valid_d) begin
                    out_data_d  = msg_d ^ ks_d;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end
            end

            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    msg_valid_d = 1'b0;
                    ks_valid_d  = 1'b0;
                    remaining_d = remaining_q - CNT_W'(1);
                    ctr_d       = ctr_inc;
                    if (remaining_q == CNT_W'(1)) begin
                        done_d        = 1'b1;
                        done_sticky_d = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        state_d = StKs;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Protocol violations: job continues, error is sticky until the next accepted start.
        if (start && (state_q != StIdle)) begin
            err_d = 1'b1;
        end
        if (aes_done && !((state_q == StWait) && !ks_valid_q)) begin
            err_d = 1'b1;
        end

        aes_start_d     = (state_d == StKs);
        in_ready_d      = (state_d == StWait) && !msg_valid_d;
        busy_d          = (state_d != StIdle);
        status_d        = {err_d, busy_d, done_sticky_d};
        status_update_d = (status_d != status_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            ctr_q           <= '0;
            remaining_q     <= '0;
            msg_q           <= '0;
            msg_valid_q     <= 1'b0;
            ks_q            <= '0;
            ks_valid_q      <= 1'b0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            aes_start_q     <= 1'b0;
            in_ready_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            done_sticky_q   <= 1'b0;
            err_q           <= 1'b0;
            status_q        <= 3'b000;
            status_update_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ctr_q           <= ctr_d;
            remaining_q     <= remaining_d;
            msg_q           <= msg_d;
            msg_valid_q     <= msg_valid_d;
            ks_q            <= ks_d;
            ks_valid_q      <= ks_valid_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            aes_start_q     <= aes_start_d;
            in_ready_q      <= in_ready_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            done_sticky_q   <= done_sticky_d;
            err_q           <= err_d;
            status_q        <= status_d;
            status_update_q <= status_update_d;
        end
    end

    assign aes_start     = aes_start_q;
    assign aes_block     = ctr_q;
    assign in_ready      = in_ready_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign status        = status_q;
    assign status_update = status_update_q;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Directed self-checking bench for aes_ctr_sequencer.
module tb_aes_ctr_sequencer;

    localparam int W     = 128;
    localparam int CTR_W = 32;
    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [W-1:0]     iv;
    logic [CNT_W-1:0] num_blocks;
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic             aes_start;
    logic [W-1:0]     aes_block;
    logic             aes_done;
    logic [W-1:0]     aes_keystream;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [2:0]       status;
    logic             status_update;

    int total  = 0;
    int passed = 0;

    aes_ctr_sequencer #(
        .W     (W),
        .CTR_W (CTR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .iv            (iv),
        .num_blocks    (num_blocks),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .aes_start     (aes_start),
        .aes_block     (aes_block),
        .aes_done      (aes_done),
        .aes_keystream (aes_keystream),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .status        (status),
        .status_update (status_update)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_job(input logic [W-1:0] v, input logic [CNT_W-1:0] n);
        start      = 1'b1;
        iv         = v;
        num_blocks = n;
        tick();
        start      = 1'b0;
    endtask

    // Called in WAIT: message arrives after md cycles, keystream after kd cycles.
    task automatic feed_block(input logic [W-1:0] msg, input logic [W-1:0] ks,
                              input int md, input int kd);
        int last;
        last = (md > kd) ? md : kd;
        for (int c = 0; c <= last; c++) begin
            in_data       = msg;
            aes_keystream = ks;
            in_valid      = (c == md);
            aes_done      = (c == kd);
            tick();
        end
        in_valid = 1'b0;
        aes_done = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; iv = '0; num_blocks = '0; in_data = '0;
        in_valid = 1'b0; aes_done = 1'b0; aes_keystream = '0; out_ready = 1'b0;
        tick();
        tick();
        total++; if ({aes_start, in_ready, out_valid} !== 3'b000)
            $display("FAIL reset_ctrl: got %b want 000", {aes_start, in_ready, out_valid});
            else passed++;
        total++; if ({busy, done, status_update} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {busy, done, status_update});
            else passed++;
        total++; if (status !== 3'b000)
            $display("FAIL reset_status: got %b want 000", status); else passed++;
        total++; if ((out_data !== '0) || (aes_block !== '0))
            $display("FAIL reset_data: got %h/%h want 0/0", out_data, aes_block); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_empty_job();
        start_job(128'h1234, 8'd0);
        total++; if (done !== 1'b1) $display("FAIL empty_done: got %b want 1", done); else passed++;
        total++; if (status !== 3'b001)
            $display("FAIL empty_status: got %b want 001", status); else passed++;
        total++; if (status_update !== 1'b1)
            $display("FAIL empty_upd: got %b want 1", status_update); else passed++;
        total++; if ({aes_start, busy} !== 2'b00)
            $display("FAIL empty_nostart: got %b want 00", {aes_start, busy}); else passed++;
        tick();
        total++; if ({done, aes_start, status_update} !== 3'b000)
            $display("FAIL empty_after: got %b want 000", {done, aes_start, status_update});
            else passed++;
    endtask

    task automatic test_sp800();
        logic [W-1:0] iv0, pt1, pt2, ct1, ct2;
        iv0 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
        pt1 = 128'h6bc1bee22e409f96e93d7e117393172a;
        pt2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        ct1 = 128'h874d6191b620e3261bef6862990db6ce;
        ct2 = 128'h9806f66b7970fdff8617187bb9fffdff;
        start_job(iv0, 8'd2);
        total++; if (aes_start !== 1'b1)
            $display("FAIL sp_start: got %b want 1", aes_start); else passed++;
        total++; if (aes_block !== iv0)
            $display("FAIL sp_block1: got %h want %h", aes_block, iv0); else passed++;
        total++; if ({busy, in_ready, status, status_update} !== 6'b1_0_010_1)
            $display("FAIL sp_ks_flags: got %b want 100101",
                     {busy, in_ready, status, status_update}); else passed++;
        tick();
        total++; if ({aes_start, in_ready} !== 2'b01)
            $display("FAIL sp_wait: got %b want 01", {aes_start, in_ready}); else passed++;
        // Keystream is the known cipher output: plaintext XOR ciphertext.
        feed_block(pt1, pt1 ^ ct1, 0, 0);
        total++; if ({out_valid, out_data} !== {1'b1, ct1})
            $display("FAIL sp_out1: got %b/%h want 1/%h", out_valid, out_data, ct1); else passed++;
        handshake();
        total++; if ({aes_start, aes_block} !== {1'b1, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00})
            $display("FAIL sp_block2: got %b/%h want 1/f0f1f2f3f4f5f6f7f8f9fafbfcfdff00",
                     aes_start, aes_block); else passed++;
        tick();
        feed_block(pt2, pt2 ^ ct2, 0, 0);
        total++; if ({out_valid, out_data} !== {1'b1, ct2})
            $display("FAIL sp_out2: got %b/%h want 1/%h", out_valid, out_data, ct2); else passed++;
        handshake();
        total++; if ({done, busy, status} !== 5'b1_0_001)
            $display("FAIL sp_done: got %b want 10001", {done, busy, status}); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL sp_done_pulse: got %b want 0", done);
            else passed++;
    endtask

    task automatic test_wrap();
        start_job({96'ha5a5a5a5_a5a5a5a5_a5a5a5a5, 32'hffffffff}, 8'd2);
        total++; if (aes_block !== {96'ha5a5a5a5_a5a5a5a5_a5a5a5a5, 32'hffffffff})
            $display("FAIL wrap_block1: got %h", aes_block); else passed++;
        tick();
        feed_block('0, 128'hdeadbeef_00000000_cafef00d_12345678, 0, 0);
        total++; if (out_data !== 128'hdeadbeef_00000000_cafef00d_12345678)
            $display("FAIL wrap_out1: got %h want deadbeef00000000cafef00d12345678", out_data);
            else passed++;
        handshake();
        total++; if (aes_block !== {96'ha5a5a5a5_a5a5a5a5_a5a5a5a5, 32'h00000000})
            $display("FAIL wrap_block2: got %h want a5a5a5a5a5a5a5a5a5a5a5a500000000",
                     aes_block); else passed++;
        tick();
        feed_block('0, '0, 0, 0);
        handshake();
        total++; if (done !== 1'b1) $display("FAIL wrap_done: got %b want 1", done); else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        start_job(128'h100, 8'd2);
        tick();
        feed_block({4{32'h11111111}}, {4{32'h22222222}}, 0, 0);
        for (int i = 0; i < 5; i++) begin
            total++; if ({out_valid, aes_start, out_data} !== {1'b1, 1'b0, {4{32'h33333333}}})
                $display("FAIL bp_hold%0d: got %b%b/%h want 10/%h", i, out_valid, aes_start,
                         out_data, {4{32'h33333333}}); else passed++;
            tick();
        end
        handshake();
        total++; if ({aes_start, out_valid} !== 2'b10)
            $display("FAIL bp_release: got %b want 10", {aes_start, out_valid}); else passed++;
        tick();
        feed_block('0, '0, 0, 0);
        handshake();
        total++; if (done !== 1'b1) $display("FAIL bp_done: got %b want 1", done); else passed++;
        tick();
    endtask

    task automatic test_order();
        logic [W-1:0] msg, ks, exp;
        msg = 128'h00112233445566778899aabbccddeeff;
        ks  = {16{8'h0f}};
        exp = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        start_job(128'h200, 8'd3);
        tick();
        feed_block(msg, ks, 0, 4);
        total++; if ({out_valid, in_ready, out_data} !== {2'b10, exp})
            $display("FAIL order_msg_first: got %b%b/%h want 10/%h", out_valid, in_ready,
                     out_data, exp); else passed++;
        handshake();
        tick();
        feed_block(msg, ks, 4, 0);
        total++; if ({out_valid, out_data} !== {1'b1, exp})
            $display("FAIL order_ks_first: got %b/%h want 1/%h", out_valid, out_data, exp);
            else passed++;
        handshake();
        tick();
        feed_block(msg, ks, 0, 0);
        total++; if ({out_valid, out_data} !== {1'b1, exp})
            $display("FAIL order_same: got %b/%h want 1/%h", out_valid, out_data, exp);
            else passed++;
        handshake();
        total++; if (done !== 1'b1) $display("FAIL order_done: got %b want 1", done);
            else passed++;
        tick();
    endtask

    task automatic test_errors();
        int done_seen;
        start_job(128'h300, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if ({status, status_update} !== 4'b110_1)
            $display("FAIL err_start_busy: got %b want 1101", {status, status_update});
            else passed++;
        feed_block(128'h5, 128'h3, 0, 0);
        total++; if (out_data !== 128'h6)
            $display("FAIL err_job_out: got %h want 6", out_data); else passed++;
        handshake();
        total++; if ({done, status} !== 4'b1_101)
            $display("FAIL err_job_done: got %b want 1101", {done, status}); else passed++;
        tick();
        start_job(128'h400, 8'd2);
        total++; if (status !== 3'b010)
            $display("FAIL err_cleared: got %b want 010", status); else passed++;
        tick();
        // Second aes_done while a keystream is already held.
        aes_done = 1'b1;
        tick();
        tick();
        aes_done = 1'b0;
        total++; if (status !== 3'b110)
            $display("FAIL err_dup_done: got %b want 110", status); else passed++;
        reset = 1'b1;
        tick();
        total++; if ({aes_start, in_ready, out_valid, busy, done, status, status_update}
                     !== 9'b0)
            $display("FAIL midreset_outs: got %b want 000000000",
                     {aes_start, in_ready, out_valid, busy, done, status, status_update});
            else passed++;
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done || aes_start) done_seen++;
        end
        total++; if (done_seen !== 0)
            $display("FAIL midreset_nodone: got %0d want 0", done_seen); else passed++;
    endtask

    initial begin
        test_reset();
        test_empty_job();
        test_sp800();
        test_wrap();
        test_backpressure();
        test_order();
        test_errors();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
